// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: request/response bus between a cache controller and main memory.
// With MEM_RANGE_CHK_EN defined the bus also carries rsp_err.
interface main_mem_responder_if;
  logic        req_valid;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef MEM_RANGE_CHK_EN
  logic        rsp_err;
  modport master(output req_valid, req_rw, req_addr, req_wdata, input rsp_ready, rsp_data, busy, rsp_err);
  modport slave(input req_valid, req_rw, req_addr, req_wdata, output rsp_ready, rsp_data, busy, rsp_err);
`else
  modport master(output req_valid, req_rw, req_addr, req_wdata, input rsp_ready, rsp_data, busy);
  modport slave(input req_valid, req_rw, req_addr, req_wdata, output rsp_ready, rsp_data, busy);
`endif
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency main memory serving 4-word line write-backs and 2-word half-line reads.
// Optional MEM_RANGE_CHK_EN flags requests whose address exceeds the backing storage.
module main_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input logic                  clk,
  input logic                  rst,
  main_mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rw_q;
  logic [ADDR_W-2:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem [2**(ADDR_W-2)];
  logic [63:0] line;
  logic accept, resp, ok;
  always_comb begin
    accept  = state_q != WAIT && bus.req_valid;
    cnt_d   = state_q == WAIT ? cnt_q - 4'd1 : accept ? 4'(LATENCY - 1) : 4'd0;
    state_d = state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
  end
  // addr_q holds addr[ADDR_W-1:1]: line index above, half select in bit 0; addr[0] never matters
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= bus.req_rw;
        addr_q  <= bus.req_addr[ADDR_W-1:1];
        wdata_q <= bus.req_wdata;
      end
    end
`ifdef MEM_RANGE_CHK_EN
  logic oor_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) oor_q <= 1'b0;
    else if (accept) oor_q <= |bus.req_addr[15:ADDR_W];
  assign ok          = !oor_q;
  assign bus.rsp_err = resp && oor_q;
`else
  assign ok = 1'b1;
`endif
  assign resp = state_q == RESP;
  assign line = mem[addr_q[ADDR_W-2:1]];
  // storage is deliberately unreset; async reset of state_q alone suppresses an aborted write
  always_ff @(posedge clk)
    if (resp && rw_q && ok) mem[addr_q[ADDR_W-2:1]] <= wdata_q;
  assign bus.rsp_ready = resp;
  assign bus.busy      = state_q != IDLE;
  assign bus.rsp_data  = resp && !rw_q && ok ? {addr_q[0] ? line[63:48] : line[47:32], addr_q[0] ? line[31:16] : line[15:0]} : 32'd0;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: randomized scoreboard bench; a word-array model predicts each response,
// a monitor compares every response, busy and idle rsp_data against the queue.
module tb_main_mem_responder;
  localparam int LAT = 4;
  localparam int AW  = 10;
  localparam int NW  = 1 << AW;
  typedef struct {logic [31:0] data; logic err; int due;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  logic [15:0] mem_m [NW];
  logic [15:0] save [4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  main_mem_responder_if bus();
  main_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic rw, input logic [15:0] a, input logic [63:0] wd);
    exp_t e;
    int b, h;
    logic oor;
    b = int'(a) & ~3;
    h = int'(a[1]);
    oor = 1'b0;
`ifdef MEM_RANGE_CHK_EN
    oor = (int'(a) >> AW) != 0;
`endif
    e.err = oor;
    e.data = 32'd0;
    e.due = 0;
    if (rw && !oor) for (int i = 0; i < 4; i++) mem_m[(b + i) % NW] = wd[16*i +: 16];
    else if (!rw && !oor) e.data = {mem_m[(b + 2 + h) % NW], mem_m[(b + h) % NW]};
    return e;
  endfunction

  // While the responder is busy the bus carries random junk that must be ignored
  task automatic issue(input logic rw, input logic [15:0] a, input logic [63:0] wd);
    logic acc;
    exp_t e;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = !bus.busy || bus.rsp_ready;
      if (acc) begin
        bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_wdata = wd;
      end else begin
        bus.req_valid = 1'($urandom); bus.req_rw = 1'($urandom);
        bus.req_addr = 16'($urandom); bus.req_wdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      if (acc) begin
        e = model(rw, a, wd);
        e.due = cyc + LAT - 1;
        q.push_back(e);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL issue_timeout addr %h got no accept want accept within 64 cycles", a);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr = 16'($urandom);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        check("busy", {63'd0, bus.busy}, {63'd0, q.size() != 0});
        if (bus.rsp_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_rsp_ready got 1 want 0 at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            check("latency", 64'(cyc), 64'(e.due));
            check("rsp_data", {32'd0, bus.rsp_data}, {32'd0, e.data});
`ifdef MEM_RANGE_CHK_EN
            check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
`endif
          end
        end else begin
          check("idle_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
`ifdef MEM_RANGE_CHK_EN
          check("idle_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
`endif
        end
      end
    end
  end

  initial begin
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 16'h0; bus.req_wdata = 64'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, bus.rsp_ready}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_data", {32'd0, bus.rsp_data}, 64'd0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NW; i += 4) issue(1'b1, 16'(i), {$urandom, $urandom});
    issue(1'b1, 16'h0010, 64'h4444_3333_2222_1111);
    issue(1'b0, 16'h0012, 64'h0);
    issue(1'b0, 16'h0011, 64'h0);
    idle(2);
    issue(1'b1, 16'h0410, 64'hdead_beef_cafe_f00d);
    issue(1'b0, 16'h0010, 64'h0);
    issue(1'b0, 16'h0413, 64'h0);
    idle(3);
    for (int i = 0; i < 4; i++) save[i] = mem_m[32 + i];
    issue(1'b1, 16'h0020, {$urandom, $urandom});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_ready", {63'd0, bus.rsp_ready}, 64'd0);
    q.delete();
    for (int i = 0; i < 4; i++) mem_m[32 + i] = save[i];
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(8);
    issue(1'b0, 16'h0020, 64'h0);
    issue(1'b0, 16'h0022, 64'h0);
    repeat (300) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
      issue(1'($urandom), $urandom_range(1) == 1 ? 16'($urandom) : 16'($urandom_range(NW - 1)), {$urandom, $urandom});
    end
    for (int n = 0; n < 64 && q.size() != 0; n++) idle(1);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
